// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT of saturating counters plus a tagged BTB, indexed by PC.
// Combinational fetch lookup, one execute-stage update per cycle, saturating statistics.
module branch_predictor_bht #(
   parameter int         INDEX_BITS = 4,
   parameter int         CTR_BITS   = 2,
   parameter int         CTR_INIT   = 2,
   parameter int         STAT_BITS  = 16,
   parameter logic [6:0] B_OP       = 7'h63,
   parameter logic [6:0] JAL_OP     = 7'h6F,
   parameter logic [6:0] JALR_OP    = 7'h67
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          lookup_pc,
   input  logic [6:0]           lookup_opcode,
   output logic                 predict_taken,
   output logic [31:0]          predict_target,
   // update_* is a one-cycle qualifier: sampled on every rising edge where
   // update_valid=1, no backpressure, one resolved instruction per cycle.
   input  logic                 update_valid,
   input  logic [31:0]          update_pc,
   input  logic [6:0]           update_opcode,
   input  logic                 update_taken,
   input  logic [31:0]          update_target,
   input  logic                 update_pred_taken,
   input  logic [31:0]          update_pred_target,
   output logic                 mispredict,
   output logic [STAT_BITS-1:0] branch_count,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam logic [CTR_BITS-1:0]  CTR_MAX   = '1;
   localparam logic [CTR_BITS-1:0]  CTR_RESET = CTR_BITS'(CTR_INIT);
   localparam logic [STAT_BITS-1:0] STAT_MAX  = '1;

   logic [CTR_BITS-1:0] ctr        [ENTRIES];
   logic                btb_valid  [ENTRIES];
   logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
   logic [31:0]         btb_target [ENTRIES];

   logic [INDEX_BITS-1:0] lk_idx, up_idx;
   logic [TAG_BITS-1:0]   lk_tag, up_tag;
   logic                  lk_hit;
   logic                  up_is_b, up_counted, up_miss;
   logic [3:0]            unused_pc_bits;

   assign lk_idx = lookup_pc[INDEX_BITS+1:2];
   assign lk_tag = lookup_pc[31:INDEX_BITS+2];
   assign up_idx = update_pc[INDEX_BITS+1:2];
   assign up_tag = update_pc[31:INDEX_BITS+2];
   assign unused_pc_bits = {lookup_pc[1:0], update_pc[1:0]};

   // Register-target jumps are never predicted, even if opcodes are reconfigured to overlap.
   always_comb begin
      lk_hit         = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
      predict_taken  = 1'b0;
      predict_target = 32'h0;
      if (lookup_opcode != JALR_OP) begin
         if (lookup_opcode == B_OP)
            predict_taken = lk_hit && ctr[lk_idx][CTR_BITS-1];
         else if (lookup_opcode == JAL_OP)
            predict_taken = lk_hit;
      end
      if (predict_taken)
         predict_target = btb_target[lk_idx];
   end

   always_comb begin
      up_is_b    = (update_opcode == B_OP);
      up_counted = update_valid && (up_is_b || (update_opcode == JAL_OP));
      up_miss    = (update_taken != update_pred_taken) ||
                   (update_taken && update_pred_taken && (update_target != update_pred_target));
   end

   // Reset wins over a concurrent update; BTB tag/target need no reset since valid gates them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i]       <= CTR_RESET;
            btb_valid[i] <= 1'b0;
         end
         mispredict       <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         mispredict <= up_counted && up_miss;
         if (up_counted) begin
            if (up_is_b) begin
               if (update_taken && ctr[up_idx] != CTR_MAX)
                  ctr[up_idx] <= ctr[up_idx] + 1'b1;
               else if (!update_taken && ctr[up_idx] != '0)
                  ctr[up_idx] <= ctr[up_idx] - 1'b1;
            end
            if (update_taken) begin
               btb_valid[up_idx]  <= 1'b1;
               btb_tag[up_idx]    <= up_tag;
               btb_target[up_idx] <= update_target;
            end
            if (branch_count != STAT_MAX)
               branch_count <= branch_count + 1'b1;
            if (up_miss && mispredict_count != STAT_MAX)
               mispredict_count <= mispredict_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: default instance plus a STAT_BITS=2
// instance sharing the same stimulus for statistics saturation.
module tb_branch_predictor_bht;

   localparam logic [6:0] B_OP    = 7'h63;
   localparam logic [6:0] JAL_OP  = 7'h6F;
   localparam logic [6:0] JALR_OP = 7'h67;
   localparam logic [6:0] ALU_OP  = 7'h33;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] lookup_pc = '0;
   logic [6:0]  lookup_opcode = '0;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        update_valid = 1'b0;
   logic [31:0] update_pc = '0;
   logic [6:0]  update_opcode = '0;
   logic        update_taken = 1'b0;
   logic [31:0] update_target = '0;
   logic        update_pred_taken = 1'b0;
   logic [31:0] update_pred_target = '0;
   logic        mispredict;
   logic [15:0] branch_count, mispredict_count;
   logic        sat_predict_taken, sat_mispredict;
   logic [31:0] sat_predict_target;
   logic [1:0]  sat_branch_count, sat_mispredict_count;

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   branch_predictor_bht u_dut (
      .clock(clock), .reset(reset),
      .lookup_pc(lookup_pc), .lookup_opcode(lookup_opcode),
      .predict_taken(predict_taken), .predict_target(predict_target),
      .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
      .update_taken(update_taken), .update_target(update_target),
      .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
      .mispredict(mispredict), .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   branch_predictor_bht #(.STAT_BITS(2)) u_sat (
      .clock(clock), .reset(reset),
      .lookup_pc(lookup_pc), .lookup_opcode(lookup_opcode),
      .predict_taken(sat_predict_taken), .predict_target(sat_predict_target),
      .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
      .update_taken(update_taken), .update_target(update_target),
      .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
      .mispredict(sat_mispredict), .branch_count(sat_branch_count),
      .mispredict_count(sat_mispredict_count)
   );

   // ---- driver tasks: all return #1 after a rising edge ----
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic idle();
      @(posedge clock); #1;
   endtask

   task automatic upd(input logic [6:0] op, input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
      update_valid = 1'b1;
      update_opcode = op;
      update_pc = pc;
      update_taken = taken;
      update_target = tgt;
      update_pred_taken = ptaken;
      update_pred_target = ptgt;
      @(posedge clock); #1;
      update_valid = 1'b0;
   endtask

   task automatic look(input logic [6:0] op, input logic [31:0] pc);
      lookup_opcode = op;
      lookup_pc = pc;
      #1;
   endtask

   // ---- scenario tasks ----
   task automatic test_reset();
      do_reset();
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL reset_taken: got %0b exp 0", predict_taken); end
      compared++; if (predict_target !== 32'h0) begin mismatched++; $display("FAIL reset_target: got %h exp 0", predict_target); end
      compared++; if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin mismatched++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", branch_count, mispredict_count); end
      compared++; if (mispredict !== 1'b0) begin mismatched++; $display("FAIL reset_mispredict: got %0b exp 0", mispredict); end
      // counter 2 -> 1 -> 2: MSB set again, BTB now valid
      upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h80) begin mismatched++; $display("FAIL readback: got %0b/%h exp 1/00000080", predict_taken, predict_target); end
      compared++; if (branch_count !== 16'd2 || mispredict_count !== 16'd1) begin mismatched++; $display("FAIL readback_counts: got %0d/%0d exp 2/1", branch_count, mispredict_count); end
      look(ALU_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0 || predict_target !== 32'h0) begin mismatched++; $display("FAIL other_opcode: got %0b/%h exp 0/0", predict_taken, predict_target); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 3; i++) upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h80) begin mismatched++; $display("FAIL sat_high: got %0b/%h exp 1/00000080", predict_taken, predict_target); end
      upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b1) begin mismatched++; $display("FAIL sat_ctr2: got %0b exp 1", predict_taken); end
      upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0 || predict_target !== 32'h0) begin mismatched++; $display("FAIL sat_ctr1: got %0b/%h exp 0/0", predict_taken, predict_target); end
      // a wrapping counter would reach 3 and predict taken on one of these
      for (int i = 0; i < 5; i++) begin
         upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
         look(B_OP, 32'h40);
         compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL sat_low step %0d: got %0b exp 0", i, predict_taken); end
      end
      upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL sat_low_plus1: got %0b exp 0", predict_taken); end
      upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b1) begin mismatched++; $display("FAIL sat_low_plus2: got %0b exp 1", predict_taken); end
   endtask

   task automatic test_tag_conflict();
      do_reset();
      upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      upd(B_OP, 32'h440, 1'b1, 32'h900, 1'b0, 32'h0);
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0 || predict_target !== 32'h0) begin mismatched++; $display("FAIL tag_old: got %0b/%h exp 0/0", predict_taken, predict_target); end
      look(B_OP, 32'h440);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h900) begin mismatched++; $display("FAIL tag_new: got %0b/%h exp 1/00000900", predict_taken, predict_target); end
   endtask

   task automatic test_jal_jalr();
      do_reset();
      upd(JAL_OP, 32'h10, 1'b1, 32'h200, 1'b0, 32'h0);
      look(JAL_OP, 32'h10);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin mismatched++; $display("FAIL jal_hit: got %0b/%h exp 1/00000200", predict_taken, predict_target); end
      look(JALR_OP, 32'h10);
      compared++; if (predict_taken !== 1'b0 || predict_target !== 32'h0) begin mismatched++; $display("FAIL jalr_lookup: got %0b/%h exp 0/0", predict_taken, predict_target); end
      idle();
      upd(JALR_OP, 32'h10, 1'b1, 32'h300, 1'b0, 32'h0);
      compared++; if (mispredict !== 1'b0) begin mismatched++; $display("FAIL jalr_pulse: got %0b exp 0", mispredict); end
      upd(JALR_OP, 32'h20, 1'b1, 32'h500, 1'b0, 32'h0);
      compared++; if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin mismatched++; $display("FAIL jalr_counts: got %0d/%0d exp 1/1", branch_count, mispredict_count); end
      look(JAL_OP, 32'h10);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin mismatched++; $display("FAIL jalr_no_write: got %0b/%h exp 1/00000200", predict_taken, predict_target); end
      look(JAL_OP, 32'h20);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL jalr_no_alloc: got %0b exp 0", predict_taken); end
   endtask

   task automatic test_mispredict();
      do_reset();
      upd(B_OP, 32'h40, 1'b1, 32'h84, 1'b1, 32'h80);
      compared++; if (mispredict !== 1'b1) begin mismatched++; $display("FAIL mp_pulse: got %0b exp 1", mispredict); end
      compared++; if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin mismatched++; $display("FAIL mp_counts: got %0d/%0d exp 1/1", branch_count, mispredict_count); end
      idle();
      compared++; if (mispredict !== 1'b0) begin mismatched++; $display("FAIL mp_one_cycle: got %0b exp 0", mispredict); end
      upd(B_OP, 32'h40, 1'b1, 32'h84, 1'b1, 32'h84);
      compared++; if (mispredict !== 1'b0 || branch_count !== 16'd2 || mispredict_count !== 16'd1) begin mismatched++; $display("FAIL mp_correct: got %0b %0d/%0d exp 0 2/1", mispredict, branch_count, mispredict_count); end
      upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b1, 32'h84);
      compared++; if (mispredict !== 1'b1) begin mismatched++; $display("FAIL mp_b2b_first: got %0b exp 1", mispredict); end
      upd(JAL_OP, 32'h10, 1'b1, 32'h200, 1'b0, 32'h0);
      compared++; if (mispredict !== 1'b1 || mispredict_count !== 16'd3) begin mismatched++; $display("FAIL mp_b2b_second: got %0b/%0d exp 1/3", mispredict, mispredict_count); end
   endtask

   task automatic test_stat_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) upd(B_OP, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      compared++; if (sat_branch_count !== 2'd3 || sat_mispredict_count !== 2'd3) begin mismatched++; $display("FAIL stat_sat: got %0d/%0d exp 3/3", sat_branch_count, sat_mispredict_count); end
      compared++; if (branch_count !== 16'd5 || mispredict_count !== 16'd5) begin mismatched++; $display("FAIL stat_wide: got %0d/%0d exp 5/5", branch_count, mispredict_count); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      upd(B_OP, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      // same index, conflicting tag, presented together with the lookup
      update_valid = 1'b1; update_opcode = B_OP; update_pc = 32'h440;
      update_taken = 1'b1; update_target = 32'h900;
      update_pred_taken = 1'b0; update_pred_target = 32'h0;
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b1 || predict_target !== 32'h80) begin mismatched++; $display("FAIL rbw_old: got %0b/%h exp 1/00000080", predict_taken, predict_target); end
      @(posedge clock); #1;
      update_valid = 1'b0;
      look(B_OP, 32'h40);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL rbw_after: got %0b exp 0", predict_taken); end
   endtask

   task automatic test_reset_update();
      // table holds 0x440 from the previous scenario
      reset = 1'b1;
      update_valid = 1'b1; update_opcode = B_OP; update_pc = 32'h80;
      update_taken = 1'b1; update_target = 32'h100;
      update_pred_taken = 1'b0; update_pred_target = 32'h0;
      @(posedge clock); #1;
      reset = 1'b0;
      update_valid = 1'b0;
      look(B_OP, 32'h440);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL rst_clear: got %0b exp 0", predict_taken); end
      look(B_OP, 32'h80);
      compared++; if (predict_taken !== 1'b0) begin mismatched++; $display("FAIL rst_discard: got %0b exp 0", predict_taken); end
      compared++; if (mispredict !== 1'b0 || branch_count !== 16'd0 || mispredict_count !== 16'd0) begin mismatched++; $display("FAIL rst_stats: got %0b %0d/%0d exp 0 0/0", mispredict, branch_count, mispredict_count); end
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_tag_conflict();
      test_jal_jalr();
      test_mispredict();
      test_stat_saturation();
      test_same_cycle();
      test_reset_update();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
